store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 11 +
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer_match.sv | 29 ++
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared defaults and entry type for the store buffer.
package store_buffer_pkg;
  localparam int SB_AW = 15;
  localparam int SB_DW = 16;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Enqueue, memory-write and dual-lookup signal bundle of the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);
  logic          enq_valid;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic          enq_ready;
  logic          mem_grant;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] lk_addr0;
  logic [AW-1:0] lk_addr1;
  logic          lk_hit0;
  logic          lk_hit1;
  logic [DW-1:0] lk_data0;
  logic [DW-1:0] lk_data1;

  modport master (
    output enq_valid, enq_addr, enq_data, mem_grant, lk_addr0, lk_addr1,
    input  enq_ready, mem_wen, mem_waddr, mem_wdata,
    input  lk_hit0, lk_hit1, lk_data0, lk_data1
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, mem_grant, lk_addr0, lk_addr1,
    output enq_ready, mem_wen, mem_waddr, mem_wdata,
    output lk_hit0, lk_hit1, lk_data0, lk_data1
  );
endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match address compare over a circular buffer starting at head.
module sb_match #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 15,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]    valid,
  input  logic [DEPTH*AW-1:0] addrs,
  input  logic [AW-1:0]       key,
  input  logic [IW-1:0]       head,
  output logic                hit,
  output logic [IW-1:0]       idx
);
  logic [IW-1:0] j;

  // Walk oldest to youngest; the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      j = head + IW'(k);
      if (valid[j] && (addrs[j*AW +: AW] == key)) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with forwarding lookups; STORE_BUFFER_COALESCE_EN
// enables in-place merging of stores to an already pending address.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = SB_AW,
  parameter  int DW    = SB_DW,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_buffer_if.slave        bus,
  output logic [CW-1:0]        count,
  output logic                 empty
);
  logic [DEPTH-1:0]    valid_q;
  logic [AW-1:0]       addr_q [DEPTH];
  logic [DW-1:0]       data_q [DEPTH];
  logic [IW-1:0]       head;
  logic [IW-1:0]       tail;
  logic [DEPTH*AW-1:0] addr_vec;
  logic                full;
  logic                drain;
  logic                enq_fire;
  logic                alloc;
  logic                hit0;
  logic                hit1;
  logic [IW-1:0]       idx0;
  logic [IW-1:0]       idx1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_vec
    assign addr_vec[i*AW +: AW] = addr_q[i];
  end

  assign empty         = (count == '0);
  assign full          = (count == CW'(DEPTH));
  assign drain         = ~empty & bus.mem_grant;
  assign bus.mem_wen   = drain;
  assign bus.mem_waddr = addr_q[head];
  assign bus.mem_wdata = data_q[head];
  assign enq_fire      = bus.enq_valid & bus.enq_ready;

`ifdef STORE_BUFFER_COALESCE_EN
  logic             coal_hit;
  logic [IW-1:0]    coal_idx;
  logic [DEPTH-1:0] head_oh;

  // The head leaving this cycle cannot absorb a store; it allocates instead.
  assign head_oh = drain ? (DEPTH'(1) << head) : '0;

  sb_match #(.DEPTH(DEPTH), .AW(AW)) u_coal (
    .valid (valid_q & ~head_oh),
    .addrs (addr_vec),
    .key   (bus.enq_addr),
    .head  (head),
    .hit   (coal_hit),
    .idx   (coal_idx)
  );

  assign bus.enq_ready = ~full | coal_hit;
  assign alloc         = enq_fire & ~coal_hit;
`else
  assign bus.enq_ready = ~full;
  assign alloc         = enq_fire;
`endif

  sb_match #(.DEPTH(DEPTH), .AW(AW)) u_lk0 (
    .valid (valid_q),
    .addrs (addr_vec),
    .key   (bus.lk_addr0),
    .head  (head),
    .hit   (hit0),
    .idx   (idx0)
  );

  sb_match #(.DEPTH(DEPTH), .AW(AW)) u_lk1 (
    .valid (valid_q),
    .addrs (addr_vec),
    .key   (bus.lk_addr1),
    .head  (head),
    .hit   (hit1),
    .idx   (idx1)
  );

  assign bus.lk_hit0  = hit0;
  assign bus.lk_hit1  = hit1;
  assign bus.lk_data0 = hit0 ? data_q[idx0] : '0;
  assign bus.lk_data1 = hit1 ? data_q[idx1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      count <= count + CW'(alloc) - CW'(drain);
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail] <= bus.enq_addr;
      data_q[tail] <= bus.enq_data;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (enq_fire && coal_hit) data_q[coal_idx] <= bus.enq_data;
`endif
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, AW=15, DW=16).
module tb_store_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  logic       empty;
  int         n_chk = 0;
  int         n_pass = 0;

  store_buffer_if #(.AW(15), .DW(16)) bus ();

  store_buffer #(.DEPTH(4), .AW(15), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, settle, and leave the caller to check.
  task automatic cyc(input logic v, input logic [14:0] a, input logic [15:0] d, input logic g);
    @(negedge clk);
    bus.enq_valid = v;
    bus.enq_addr  = a;
    bus.enq_data  = d;
    bus.mem_grant = g;
    #1;
  endtask

  task automatic test_reset();
    bus.lk_addr0 = 15'h0;
    bus.lk_addr1 = 15'h1;
    cyc(1'b0, 15'h0, 16'h0, 1'b1);
    n_chk++; if (bus.enq_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.enq_ready); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (bus.mem_wen !== 1'b0) $display("FAIL rst_wen: got %b want 0", bus.mem_wen); else n_pass++;
    n_chk++; if (bus.lk_hit0 !== 1'b0 || bus.lk_hit1 !== 1'b0) $display("FAIL rst_hit: got %b%b want 00", bus.lk_hit0, bus.lk_hit1); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    cyc(1'b1, 15'h0010, 16'hAAAA, 1'b1);
    n_chk++; if (bus.mem_wen !== 1'b0) $display("FAIL order_no_bypass: got wen %b want 0", bus.mem_wen); else n_pass++;
    cyc(1'b1, 15'h0011, 16'hBBBB, 1'b1);
    n_chk++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 15'h0010 || bus.mem_wdata !== 16'hAAAA)
      $display("FAIL order_first: got wen %b %h<-%h want 1 0010<-aaaa", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); else n_pass++;
    cyc(1'b0, 15'h0, 16'h0, 1'b1);
    n_chk++; if (count !== 3'd1) $display("FAIL order_count_same: got %0d want 1", count); else n_pass++;
    n_chk++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 15'h0011 || bus.mem_wdata !== 16'hBBBB)
      $display("FAIL order_second: got wen %b %h<-%h want 1 0011<-bbbb", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); else n_pass++;
    cyc(1'b0, 15'h0, 16'h0, 1'b1);
    n_chk++; if (empty !== 1'b1 || bus.mem_wen !== 1'b0) $display("FAIL order_drained: got empty %b wen %b want 1 0", empty, bus.mem_wen); else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 15'h0040 + 15'(i), 16'h1000 + 16'(i), 1'b0);
      n_chk++; if (bus.enq_ready !== 1'b1) $display("FAIL full_fill%0d: got ready %b want 1", i, bus.enq_ready); else n_pass++;
    end
    cyc(1'b1, 15'h0044, 16'h1004, 1'b0);
    n_chk++; if (bus.enq_ready !== 1'b0 || count !== 3'd4) $display("FAIL full_refuse: got ready %b count %0d want 0 4", bus.enq_ready, count); else n_pass++;
    cyc(1'b1, 15'h0044, 16'h1004, 1'b1);
    n_chk++; if (bus.enq_ready !== 1'b0) $display("FAIL full_drain_refuse: got ready %b want 0", bus.enq_ready); else n_pass++;
    n_chk++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 15'h0040) $display("FAIL full_drain0: got wen %b addr %h want 1 0040", bus.mem_wen, bus.mem_waddr); else n_pass++;
    cyc(1'b1, 15'h0044, 16'h1004, 1'b1);
    n_chk++; if (count !== 3'd3 || bus.enq_ready !== 1'b1) $display("FAIL full_after_drain: got count %0d ready %b want 3 1", count, bus.enq_ready); else n_pass++;
    n_chk++; if (bus.mem_waddr !== 15'h0041 || bus.mem_wdata !== 16'h1001) $display("FAIL full_drain1: got %h<-%h want 0041<-1001", bus.mem_waddr, bus.mem_wdata); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 15'h0, 16'h0, 1'b1);
      n_chk++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 15'h0042 + 15'(i) || bus.mem_wdata !== 16'h1002 + 16'(i))
        $display("FAIL full_drain%0d: got wen %b %h<-%h want 1 %h<-%h", i + 2, bus.mem_wen, bus.mem_waddr, bus.mem_wdata, 15'h0042 + 15'(i), 16'h1002 + 16'(i)); else n_pass++;
    end
    cyc(1'b0, 15'h0, 16'h0, 1'b1);
    n_chk++; if (empty !== 1'b1 || bus.mem_wen !== 1'b0) $display("FAIL full_empty: got empty %b wen %b want 1 0", empty, bus.mem_wen); else n_pass++;
  endtask

  task automatic test_youngest();
    logic [2:0] exp_cnt;
`ifdef STORE_BUFFER_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    bus.lk_addr0 = 15'h0020;
    cyc(1'b1, 15'h0020, 16'h1111, 1'b0);
    cyc(1'b1, 15'h0020, 16'h2222, 1'b0);
    n_chk++; if (bus.lk_hit0 !== 1'b1 || bus.lk_data0 !== 16'h1111) $display("FAIL young_first: got %b %h want 1 1111", bus.lk_hit0, bus.lk_data0); else n_pass++;
    cyc(1'b0, 15'h0, 16'h0, 1'b0);
    n_chk++; if (bus.lk_hit0 !== 1'b1 || bus.lk_data0 !== 16'h2222) $display("FAIL young_hit: got %b %h want 1 2222", bus.lk_hit0, bus.lk_data0); else n_pass++;
    n_chk++; if (count !== exp_cnt) $display("FAIL young_count: got %0d want %0d", count, exp_cnt); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 15'h0, 16'h0, 1'b1);
      if (empty) break;
      n_chk++; if (bus.lk_hit0 !== 1'b1 || bus.lk_data0 !== 16'h2222) $display("FAIL young_during_drain: got %b %h want 1 2222", bus.lk_hit0, bus.lk_data0); else n_pass++;
    end
    n_chk++; if (empty !== 1'b1 || bus.lk_hit0 !== 1'b0 || bus.lk_data0 !== 16'h0)
      $display("FAIL young_gone: got empty %b hit %b data %h want 1 0 0000", empty, bus.lk_hit0, bus.lk_data0); else n_pass++;
  endtask

  task automatic test_dual_lookup();
    bus.lk_addr0 = 15'h0030;
    bus.lk_addr1 = 15'h0031;
    cyc(1'b1, 15'h0030, 16'h5555, 1'b0);
    n_chk++; if (bus.lk_hit0 !== 1'b0) $display("FAIL dual_same_cycle: got hit0 %b want 0", bus.lk_hit0); else n_pass++;
    cyc(1'b1, 15'h0031, 16'h7777, 1'b0);
    n_chk++; if (bus.lk_hit0 !== 1'b1 || bus.lk_data0 !== 16'h5555) $display("FAIL dual_hit0: got %b %h want 1 5555", bus.lk_hit0, bus.lk_data0); else n_pass++;
    n_chk++; if (bus.lk_hit1 !== 1'b0 || bus.lk_data1 !== 16'h0) $display("FAIL dual_miss1: got %b %h want 0 0000", bus.lk_hit1, bus.lk_data1); else n_pass++;
    cyc(1'b1, 15'h0032, 16'h8888, 1'b0);
    n_chk++; if (bus.lk_hit1 !== 1'b1 || bus.lk_data1 !== 16'h7777) $display("FAIL dual_hit1: got %b %h want 1 7777", bus.lk_hit1, bus.lk_data1); else n_pass++;
    bus.lk_addr1 = 15'h0030;
    #1;
    n_chk++; if (bus.lk_hit1 !== 1'b1 || bus.lk_data1 !== 16'h5555) $display("FAIL dual_same_entry: got %b %h want 1 5555", bus.lk_hit1, bus.lk_data1); else n_pass++;
    cyc(1'b0, 15'h0, 16'h0, 1'b0);
    n_chk++; if (count !== 3'd3) $display("FAIL dual_count: got %0d want 3", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    bus.mem_grant = 1'b1;
    #1;
    n_chk++; if (count !== 3'd0 || empty !== 1'b1 || bus.enq_ready !== 1'b1)
      $display("FAIL mid_rst_state: got count %0d empty %b ready %b want 0 1 1", count, empty, bus.enq_ready); else n_pass++;
    n_chk++; if (bus.mem_wen !== 1'b0 || bus.lk_hit0 !== 1'b0) $display("FAIL mid_rst_out: got wen %b hit0 %b want 0 0", bus.mem_wen, bus.lk_hit0); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 15'h0, 16'h0, 1'b1);
      n_chk++; if (bus.mem_wen !== 1'b0) $display("FAIL mid_rst_hold%0d: got wen %b want 0", i, bus.mem_wen); else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 15'h0, 16'h0, 1'b1);
      n_chk++; if (bus.mem_wen !== 1'b0 || empty !== 1'b1) $display("FAIL mid_rst_after%0d: got wen %b empty %b want 0 1", i, bus.mem_wen, empty); else n_pass++;
    end
  endtask

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_addr  = '0;
    bus.enq_data  = '0;
    bus.mem_grant = 1'b0;
    bus.lk_addr0  = '0;
    bus.lk_addr1  = '0;
    test_reset();
    test_in_order();
    test_full();
    test_youngest();
    test_dual_lookup();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
